alu_arbiter: RTL and testbench

Shares the single 32-bit ALU datapath between two requesters: port 0 (pipeline execute stage) and port 1 (branch/compare helper). The block arbitrates requests, registers the winning operands and function code, drives the ALU for one cycle, captures S/Z/V/N, and returns them to the winning port over a valid/ready handshake. Only one operation is in flight at a time.

---
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and ALU-side signals for alu_arbiter.
// slave is the arbiter's view; master is the requesters-plus-ALU view.
interface alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int FUN_W  = 6
);
   logic              iReqValid0, iReqValid1;
   logic              oReqReady0, oReqReady1;
   logic [DATA_W-1:0] iReqA0, iReqA1, iReqB0, iReqB1;
   logic [FUN_W-1:0]  iReqFun0, iReqFun1;
   logic              iReqSign0, iReqSign1;
   logic              oRspValid0, oRspValid1;
   logic              iRspReady0, iRspReady1;
   logic [DATA_W-1:0] oRspS;
   logic              oRspZ, oRspV, oRspN;
   logic [DATA_W-1:0] oALUA, oALUB;
   logic [FUN_W-1:0]  oALUFun;
   logic              oALUSign;
   logic [DATA_W-1:0] iALUS;
   logic              iALUZ, iALUV, iALUN;

   modport slave (
      input  iReqValid0, iReqValid1, iReqA0, iReqA1, iReqB0, iReqB1,
             iReqFun0, iReqFun1, iReqSign0, iReqSign1, iRspReady0, iRspReady1,
             iALUS, iALUZ, iALUV, iALUN,
      output oReqReady0, oReqReady1, oRspValid0, oRspValid1,
             oRspS, oRspZ, oRspV, oRspN, oALUA, oALUB, oALUFun, oALUSign
   );

   modport master (
      output iReqValid0, iReqValid1, iReqA0, iReqA1, iReqB0, iReqB1,
             iReqFun0, iReqFun1, iReqSign0, iReqSign1, iRspReady0, iRspReady1,
             iALUS, iALUZ, iALUV, iALUN,
      input  oReqReady0, oReqReady1, oRspValid0, oRspValid1,
             oRspS, oRspZ, oRspV, oRspN, oALUA, oALUB, oALUFun, oALUSign
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one 32-bit ALU; one operation in flight (IDLE/EXEC/RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int FUN_W  = 6
) (
   input  logic         iClk,
   input  logic         iReset,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t state, state_nxt;
   logic   grant;
   logic   accept;
   logic   rsp_ready;

   logic signed [DATA_W-1:0] opa_p0, opb_p0;
   logic [FUN_W-1:0]         fun_p0;
   logic                     sign_p0;
   logic                     tag_p0;

   logic signed [DATA_W-1:0] rsp_s_p1;
   logic                     rsp_z_p1, rsp_v_p1, rsp_n_p1;

`ifdef ALU_ARB_RR_EN
   logic last_grant;
`endif

   always_comb begin
      grant = 1'b0;
      if (bus.iReqValid0 && bus.iReqValid1) begin
`ifdef ALU_ARB_RR_EN
         // port not granted most recently wins the contest
         grant = ~last_grant;
`else
         grant = 1'b0;
`endif
      end else if (bus.iReqValid1) begin
         grant = 1'b1;
      end
   end

   assign accept    = (state == IDLE) && (bus.iReqValid0 || bus.iReqValid1) && !iReset;
   assign rsp_ready = tag_p0 ? bus.iRspReady1 : bus.iRspReady0;

   assign bus.oReqReady0 = accept && !grant;
   assign bus.oReqReady1 = accept && grant;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) state <= IDLE;
      else        state <= state_nxt;
   end

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge iClk) begin
      if (iReset)      last_grant <= 1'b1;
      else if (accept) last_grant <= grant;
   end
`endif

   // p0: operand register, loaded from the winning port on accept
   always_ff @(posedge iClk) begin
      if (iReset) begin
         opa_p0  <= '0;
         opb_p0  <= '0;
         fun_p0  <= '0;
         sign_p0 <= 1'b0;
         tag_p0  <= 1'b0;
      end else if (accept) begin
         opa_p0  <= grant ? bus.iReqA1    : bus.iReqA0;
         opb_p0  <= grant ? bus.iReqB1    : bus.iReqB0;
         fun_p0  <= grant ? bus.iReqFun1  : bus.iReqFun0;
         sign_p0 <= grant ? bus.iReqSign1 : bus.iReqSign0;
         tag_p0  <= grant;
      end
   end

   assign bus.oALUA    = opa_p0;
   assign bus.oALUB    = opb_p0;
   assign bus.oALUFun  = fun_p0;
   assign bus.oALUSign = sign_p0;

   // p1: response register, captured from the ALU at the end of EXEC
   always_ff @(posedge iClk) begin
      if (iReset) begin
         rsp_s_p1 <= '0;
         rsp_z_p1 <= 1'b0;
         rsp_v_p1 <= 1'b0;
         rsp_n_p1 <= 1'b0;
      end else if (state == EXEC) begin
         rsp_s_p1 <= bus.iALUS;
         rsp_z_p1 <= bus.iALUZ;
         rsp_v_p1 <= bus.iALUV;
         rsp_n_p1 <= bus.iALUN;
      end
   end

   assign bus.oRspValid0 = (state == RESP) && !tag_p0;
   assign bus.oRspValid1 = (state == RESP) && tag_p0;
   assign bus.oRspS      = rsp_s_p1;
   assign bus.oRspZ      = rsp_z_p1;
   assign bus.oRspV      = rsp_v_p1;
   assign bus.oRspN      = rsp_n_p1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single operations plus
// contention, reset-in-flight and late-requester sequences.
module tb_alu_arbiter;
   localparam int DATA_W = 32;
   localparam int FUN_W  = 6;
   localparam logic [5:0] F_ADD = 6'b000000;
   localparam logic [5:0] F_SUB = 6'b000001;

   logic iClk = 1'b0;
   logic iReset;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 iClk = ~iClk;

   alu_arbiter_if #(.DATA_W(DATA_W), .FUN_W(FUN_W)) bus ();

   alu_arbiter #(.DATA_W(DATA_W), .FUN_W(FUN_W)) dut (
      .iClk  (iClk),
      .iReset(iReset),
      .bus   (bus)
   );

   // Behavioural ALU: ADD/SUB with signed overflow; other codes give S=0,Z=1
   logic [31:0] alu_s;
   always_comb begin
      alu_s     = 32'd0;
      bus.iALUS = 32'd0;
      bus.iALUZ = 1'b1;
      bus.iALUV = 1'b0;
      bus.iALUN = 1'b0;
      if (bus.oALUFun == F_ADD || bus.oALUFun == F_SUB) begin
         if (bus.oALUFun == F_ADD) begin
            alu_s     = bus.oALUA + bus.oALUB;
            bus.iALUV = bus.oALUSign && (bus.oALUA[31] == bus.oALUB[31]) && (alu_s[31] != bus.oALUA[31]);
         end else begin
            alu_s     = bus.oALUA - bus.oALUB;
            bus.iALUV = bus.oALUSign && (bus.oALUA[31] != bus.oALUB[31]) && (alu_s[31] != bus.oALUA[31]);
         end
         bus.iALUS = alu_s;
         bus.iALUZ = (alu_s == 32'd0);
         bus.iALUN = bus.oALUSign && alu_s[31];
      end
   end

   typedef struct {
      int          port;
      logic [31:0] a, b;
      logic [5:0]  fun;
      logic        sign;
      int          bp;
      logic [31:0] s;
      logic        z, v, n;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic s);
      if (p == 0) begin
         bus.iReqValid0 = v; bus.iReqA0 = a; bus.iReqB0 = b; bus.iReqFun0 = f; bus.iReqSign0 = s;
      end else begin
         bus.iReqValid1 = v; bus.iReqA1 = a; bus.iReqB1 = b; bus.iReqFun1 = f; bus.iReqSign1 = s;
      end
   endtask

   function automatic logic rdy(input int p);
      return (p == 0) ? bus.oReqReady0 : bus.oReqReady1;
   endfunction

   function automatic logic rvld(input int p);
      return (p == 0) ? bus.oRspValid0 : bus.oRspValid1;
   endfunction

   task automatic set_rsp_ready(input int p, input logic v);
      if (p == 0) bus.iRspReady0 = v;
      else        bus.iRspReady1 = v;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, ".ready0"}, bus.oReqReady0, 0);
      chk({nm, ".ready1"}, bus.oReqReady1, 0);
      chk({nm, ".rspvalid0"}, bus.oRspValid0, 0);
      chk({nm, ".rspvalid1"}, bus.oRspValid1, 0);
      chk({nm, ".rspS"}, bus.oRspS, 0);
      chk({nm, ".rspZVN"}, {bus.oRspZ, bus.oRspV, bus.oRspN}, 0);
      chk({nm, ".aluA"}, bus.oALUA, 0);
      chk({nm, ".aluB"}, bus.oALUB, 0);
      chk({nm, ".aluFun"}, bus.oALUFun, 0);
      chk({nm, ".aluSign"}, bus.oALUSign, 0);
   endtask

   // One request from port p from IDLE; response ready withheld for bp RESP cycles
   task automatic issue(input string nm, input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] f, input logic sg, input int bp,
                        input logic [31:0] es, input logic ez, input logic ev, input logic en);
      @(negedge iClk);
      set_req(p, 1'b1, a, b, f, sg);
      set_rsp_ready(p, bp == 0);
      set_rsp_ready(1 - p, 1'b1);
      #1;
      chk({nm, ".ready"}, rdy(p), 1);
      chk({nm, ".ready_other"}, rdy(1 - p), 0);
      @(posedge iClk);
      #1;
      set_req(p, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      @(negedge iClk);
      chk({nm, ".exec_aluA"}, bus.oALUA, a);
      chk({nm, ".exec_aluB"}, bus.oALUB, b);
      chk({nm, ".exec_aluFunSign"}, {bus.oALUFun, bus.oALUSign}, {f, sg});
      chk({nm, ".exec_rspvalid"}, rvld(p), 0);
      @(negedge iClk);
      chk({nm, ".rspvalid"}, rvld(p), 1);
      chk({nm, ".rspvalid_other"}, rvld(1 - p), 0);
      chk({nm, ".S"}, bus.oRspS, es);
      chk({nm, ".ZVN"}, {bus.oRspZ, bus.oRspV, bus.oRspN}, {ez, ev, en});
      for (int k = 1; k <= bp; k++) begin
         @(negedge iClk);
         chk({nm, ".held_valid"}, rvld(p), 1);
         chk({nm, ".held_S"}, bus.oRspS, es);
         chk({nm, ".held_Z"}, bus.oRspZ, ez);
         if (k == bp) set_rsp_ready(p, 1'b1);
      end
      @(negedge iClk);
      chk({nm, ".after_handshake"}, rvld(p), 0);
      bus.iRspReady0 = 1'b0;
      bus.iRspReady1 = 1'b0;
   endtask

   int grants[4];
   int gcyc[4];
   int ng;
   int r1_seen;

   initial begin
      vecs[0] = '{port:0, a:32'd5,          b:32'd7, fun:F_ADD, sign:1'b0, bp:0, s:32'd12,         z:1'b0, v:1'b0, n:1'b0};
      vecs[1] = '{port:1, a:32'd3,          b:32'd3, fun:F_SUB, sign:1'b1, bp:4, s:32'd0,          z:1'b1, v:1'b0, n:1'b0};
      vecs[2] = '{port:0, a:32'h7FFFFFFF,   b:32'd1, fun:F_ADD, sign:1'b1, bp:0, s:32'h80000000,   z:1'b0, v:1'b1, n:1'b1};
      vecs[3] = '{port:1, a:32'd10,         b:32'd3, fun:F_SUB, sign:1'b0, bp:1, s:32'd7,          z:1'b0, v:1'b0, n:1'b0};
      vecs[4] = '{port:0, a:32'd5,          b:32'd5, fun:6'h3F, sign:1'b0, bp:0, s:32'd0,          z:1'b1, v:1'b0, n:1'b0};
      vecs[5] = '{port:1, a:32'd0,          b:32'd1, fun:F_SUB, sign:1'b1, bp:2, s:32'hFFFFFFFF,   z:1'b0, v:1'b0, n:1'b1};
      vecs[6] = '{port:0, a:32'h80000000,   b:32'd1, fun:F_SUB, sign:1'b1, bp:0, s:32'h7FFFFFFF,   z:1'b0, v:1'b1, n:1'b0};

      iReset = 1'b1;
      set_req(0, 1'b1, 32'd1, 32'd2, F_ADD, 1'b0);
      set_req(1, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      bus.iRspReady0 = 1'b0;
      bus.iRspReady1 = 1'b0;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      chk_reset_outputs("reset");
      set_req(0, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      @(posedge iClk);
      #1 iReset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         issue($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sign,
               vecs[i].bp, vecs[i].s, vecs[i].z, vecs[i].v, vecs[i].n);
      end

      // Contention: both ports request continuously, fresh pointer after reset
      @(negedge iClk);
      iReset = 1'b1;
      @(negedge iClk);
      iReset = 1'b0;
      set_req(0, 1'b1, 32'd1, 32'd1, F_ADD, 1'b0);
      set_req(1, 1'b1, 32'd2, 32'd2, F_ADD, 1'b0);
      bus.iRspReady0 = 1'b1;
      bus.iRspReady1 = 1'b1;
      ng = 0;
      r1_seen = 0;
      for (int c = 0; c < 30 && ng < 4; c++) begin
         #1;
         if (bus.oReqReady1) r1_seen++;
         if (bus.oReqReady0 || bus.oReqReady1) begin
            grants[ng] = bus.oReqReady1 ? 1 : 0;
            gcyc[ng]   = c;
            ng++;
         end
         @(negedge iClk);
      end
      set_req(0, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      set_req(1, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      chk("contend.grant_count", ng, 4);
      for (int k = 0; k < ng; k++) begin
`ifdef ALU_ARB_RR_EN
         chk($sformatf("contend.grant%0d", k), grants[k], k % 2);
`else
         chk($sformatf("contend.grant%0d", k), grants[k], 0);
`endif
         if (k > 0) chk($sformatf("contend.interval%0d", k), gcyc[k] - gcyc[k-1], 3);
      end
`ifndef ALU_ARB_RR_EN
      chk("contend.ready1_never", r1_seen, 0);
`endif
      repeat (4) @(negedge iClk);
      bus.iRspReady0 = 1'b0;
      bus.iRspReady1 = 1'b0;

      // Reset during EXEC drops the operation
      @(negedge iClk);
      set_req(0, 1'b1, 32'd9, 32'd1, F_ADD, 1'b0);
      bus.iRspReady0 = 1'b1;
      #1 chk("rst_exec.ready0", bus.oReqReady0, 1);
      @(posedge iClk);
      #1;
      set_req(0, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      iReset = 1'b1;
      @(posedge iClk);
      #1 iReset = 1'b0;
      @(negedge iClk);
      chk_reset_outputs("rst_exec");
      for (int k = 0; k < 3; k++) begin
         @(negedge iClk);
         chk($sformatf("rst_exec.no_rsp%0d", k), bus.oRspValid0, 0);
      end
      bus.iRspReady0 = 1'b0;
      issue("post_rst", 0, 32'd9, 32'd1, F_ADD, 1'b0, 0, 32'd10, 1'b0, 1'b0, 1'b0);

      // Port 1 arrives while port 0 is in flight
      @(negedge iClk);
      set_req(0, 1'b1, 32'd20, 32'd22, F_ADD, 1'b0);
      #1 chk("late.ready0", bus.oReqReady0, 1);
      @(posedge iClk);
      #1;
      set_req(0, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      set_req(1, 1'b1, 32'd50, 32'd8, F_SUB, 1'b0);
      @(negedge iClk);
      chk("late.ready1_exec", bus.oReqReady1, 0);
      @(negedge iClk);
      chk("late.ready1_resp", bus.oReqReady1, 0);
      chk("late.rspvalid0", bus.oRspValid0, 1);
      chk("late.S0", bus.oRspS, 32'd42);
      bus.iRspReady0 = 1'b1;
      @(negedge iClk);
      chk("late.ready1_idle", bus.oReqReady1, 1);
      chk("late.rspvalid0_done", bus.oRspValid0, 0);
      @(posedge iClk);
      #1;
      set_req(1, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      bus.iRspReady0 = 1'b0;
      bus.iRspReady1 = 1'b1;
      @(negedge iClk);
      @(negedge iClk);
      chk("late.rspvalid1", bus.oRspValid1, 1);
      chk("late.S1", bus.oRspS, 32'd42);
      @(negedge iClk);
      chk("late.rspvalid1_done", bus.oRspValid1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
